// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared fleet state enum and screen position type
package enemy_pkg;

  typedef logic [9:0] pos_t;

  typedef enum logic [2:0] {
    IDLE,
    MOVE_RIGHT,
    MOVE_LEFT,
    CLEARED,
    LANDED
  } fleet_state_e;

endpackage

// File: rtl/enemy_fleet_counter.sv
// rtl/enemy_fleet_counter.sv - frame counter producing one move tick every period frames
module enemy_fleet_counter #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [width_p-1:0] period_i,
  output logic               tick_o
);

  logic [width_p-1:0] r_cnt;
  logic [width_p-1:0] r_period;

  // period is latched only at a wrap so a change mid-interval applies to the next one
  assign tick_o = en_i && (r_cnt == (r_period - width_p'(1)));

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_cnt    <= '0;
      r_period <= period_i;
    end else if (tick_o) begin
      r_cnt    <= '0;
      r_period <= period_i;
    end else if (en_i) begin
      r_cnt <= r_cnt + width_p'(1);
    end
  end

endmodule

// File: rtl/enemy_fleet.sv
// rtl/enemy_fleet.sv - row of enemy ships that marches, bounces, descends and takes hits
// Define ENEMY_FLEET_SPEEDUP_EN to shorten the move period as ships are destroyed.
module enemy_fleet
  import enemy_pkg::*;
#(
  parameter int num_ships_p       = 8,
  parameter int ship_width_p      = 40,
  parameter int ship_height_p     = 20,
  parameter int spacing_p         = 20,
  parameter int step_x_p          = 10,
  parameter int step_y_p          = 20,
  parameter int left_start_p      = 10,
  parameter int top_start_p       = 40,
  parameter int screen_right_p    = 639,
  parameter int land_line_p       = 440,
  parameter int frames_per_move_p = 30,
  parameter int min_period_p      = 4,
  localparam int idx_w_lp = (num_ships_p > 1) ? $clog2(num_ships_p) : 1,
  localparam int cnt_w_lp = $clog2(num_ships_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_i,
  input  logic                     start_i,
  input  logic                     hit_v_i,
  input  logic [idx_w_lp-1:0]      hit_idx_i,
  output logic [10*num_ships_p-1:0] ship_left_o,
  output logic [9:0]               top_pos_o,
  output logic [9:0]               bot_pos_o,
  output logic [num_ships_p-1:0]   alive_o,
  output logic [cnt_w_lp-1:0]      alive_cnt_o,
  output logic                     moving_o,
  output logic                     cleared_o,
  output logic                     landed_o
);

  localparam int pitch_lp = ship_width_p + spacing_p;
  localparam logic [num_ships_p-1:0] one_lp = 1;

  fleet_state_e           r_state;
  fleet_state_e           w_next_state;
  pos_t                   r_left;
  pos_t                   r_top;
  logic [num_ships_p-1:0] r_alive;
  logic                   r_moving;
  logic                   r_cleared;
  logic                   r_landed;

  logic [num_ships_p-1:0] w_hit_mask;
  logic [num_ships_p-1:0] w_alive_next;
  logic                   w_hit;
  logic                   w_start;
  logic                   w_tick;
  logic [3:0]             w_hi_idx;
  logic [3:0]             w_lo_idx;
  pos_t                   w_hi_left;
  pos_t                   w_left_edge;
  logic [10:0]            w_right_edge;
  logic                   w_right_ok;
  logic                   w_left_ok;
  pos_t                   w_top_desc;
  logic                   w_land;
  logic [7:0]             w_period;

  function automatic logic [3:0] highest_live(input logic [num_ships_p-1:0] mask);
    highest_live = 4'd0;
    for (int k = 0; k < num_ships_p; k++)
      if (mask[k]) highest_live = 4'(k);
  endfunction

  function automatic logic [3:0] lowest_live(input logic [num_ships_p-1:0] mask);
    lowest_live = 4'd0;
    for (int k = num_ships_p - 1; k >= 0; k--)
      if (mask[k]) lowest_live = 4'(k);
  endfunction

  function automatic logic [cnt_w_lp-1:0] count_live(input logic [num_ships_p-1:0] mask);
    count_live = '0;
    for (int k = 0; k < num_ships_p; k++)
      count_live = count_live + cnt_w_lp'(mask[k]);
  endfunction

  // bounce edges follow the outermost surviving ships, evaluated on the pre-hit mask
  assign w_hi_idx     = highest_live(r_alive);
  assign w_lo_idx     = lowest_live(r_alive);
  assign w_hi_left    = r_left + pos_t'(w_hi_idx * pitch_lp);
  assign w_right_edge = 11'(w_hi_left) + 11'(ship_width_p - 1);
  assign w_right_ok   = (w_right_edge + 11'(step_x_p)) <= 11'(screen_right_p);
  assign w_left_edge  = r_left + pos_t'(w_lo_idx * pitch_lp);
  assign w_left_ok    = w_left_edge >= pos_t'(step_x_p);
  assign w_top_desc   = r_top + pos_t'(step_y_p);
  assign w_land       = (11'(w_top_desc) + 11'(ship_height_p)) >= 11'(land_line_p);

  assign w_hit_mask   = one_lp << hit_idx_i;
  assign w_hit        = r_moving && hit_v_i && (int'(hit_idx_i) < num_ships_p)
                        && (|(r_alive & w_hit_mask));
  assign w_alive_next = w_hit ? (r_alive & ~w_hit_mask) : r_alive;
  assign w_start      = start_i && ((r_state == IDLE) || (r_state == CLEARED) || (r_state == LANDED));

`ifdef ENEMY_FLEET_SPEEDUP_EN
  logic [7:0] w_unused_period;
  assign w_unused_period = 8'(frames_per_move_p);
  assign w_period        = 8'(min_period_p) + 8'(alive_cnt_o);
`else
  logic [7:0] w_unused_period;
  assign w_unused_period = 8'(min_period_p);
  assign w_period        = 8'(frames_per_move_p);
`endif

  enemy_fleet_counter #(.width_p(8)) u_move_counter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (w_start),
    .en_i     (frame_i && r_moving),
    .period_i (w_period),
    .tick_o   (w_tick)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, CLEARED, LANDED: if (start_i) w_next_state = MOVE_RIGHT;
      MOVE_RIGHT: if (w_tick && !w_right_ok) w_next_state = w_land ? LANDED : MOVE_LEFT;
      MOVE_LEFT:  if (w_tick && !w_left_ok) w_next_state = w_land ? LANDED : MOVE_RIGHT;
      default:    w_next_state = IDLE;
    endcase
    if (w_hit && (w_alive_next == '0)) w_next_state = CLEARED;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_left    <= pos_t'(left_start_p);
      r_top     <= pos_t'(top_start_p);
      r_alive   <= '1;
      r_moving  <= 1'b0;
      r_cleared <= 1'b0;
      r_landed  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_moving  <= (w_next_state == MOVE_RIGHT) || (w_next_state == MOVE_LEFT);
      r_cleared <= (w_next_state == CLEARED);
      r_landed  <= (w_next_state == LANDED);
      if (w_start) begin
        r_left  <= pos_t'(left_start_p);
        r_top   <= pos_t'(top_start_p);
        r_alive <= '1;
      end else begin
        if (w_hit) r_alive <= w_alive_next;
        if (w_tick) begin
          if (r_state == MOVE_RIGHT) begin
            if (w_right_ok) r_left <= r_left + pos_t'(step_x_p);
            else            r_top  <= w_top_desc;
          end else begin
            if (w_left_ok) r_left <= r_left - pos_t'(step_x_p);
            else           r_top  <= w_top_desc;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < num_ships_p; k++) begin : g_ship
    assign ship_left_o[10*k +: 10] = r_left + pos_t'(k * pitch_lp);
  end

  assign top_pos_o   = r_top;
  assign bot_pos_o   = r_top + pos_t'(ship_height_p - 1);
  assign alive_o     = r_alive;
  assign alive_cnt_o = count_live(r_alive);
  assign moving_o    = r_moving;
  assign cleared_o   = r_cleared;
  assign landed_o    = r_landed;

endmodule

// File: tb/tb_enemy_fleet.sv
// tb/tb_enemy_fleet.sv - scoreboard bench for enemy_fleet
// Expected snapshots are queued by the stimulus and popped when outputs change or a probe is raised.
module tb_enemy_fleet;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        frame_i = 1'b0;
  logic        start_i = 1'b0;
  logic        hit_v_i = 1'b0;
  logic [2:0]  hit_idx_i = 3'd0;
  logic [79:0] ship_left_o;
  logic [9:0]  top_pos_o;
  logic [9:0]  bot_pos_o;
  logic [7:0]  alive_o;
  logic [3:0]  alive_cnt_o;
  logic        moving_o;
  logic        cleared_o;
  logic        landed_o;

  typedef struct {
    string      tag;
    int         left;
    int         top;
    logic [7:0] alive;
    logic       mv;
    logic       cl;
    logic       ld;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  logic [79:0] want_ships;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        armed = 1'b0;
  logic        probe = 1'b0;
  logic        done = 1'b0;
  logic        reported = 1'b0;
  logic [20:0] prev_obs = '0;
  logic [20:0] obs;

  enemy_fleet dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .frame_i     (frame_i),
    .start_i     (start_i),
    .hit_v_i     (hit_v_i),
    .hit_idx_i   (hit_idx_i),
    .ship_left_o (ship_left_o),
    .top_pos_o   (top_pos_o),
    .bot_pos_o   (bot_pos_o),
    .alive_o     (alive_o),
    .alive_cnt_o (alive_cnt_o),
    .moving_o    (moving_o),
    .cleared_o   (cleared_o),
    .landed_o    (landed_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs = {top_pos_o, alive_o, moving_o, cleared_o, landed_o};

  always @(negedge clk_i) begin
    if (armed && ((obs !== prev_obs) || probe)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got top=%0d alive=%h mv=%b cl=%b ld=%b, want no output change",
                 top_pos_o, alive_o, moving_o, cleared_o, landed_o);
      end else begin
        cur_e = exp_q.pop_front();
        for (int k = 0; k < 8; k++) want_ships[10*k +: 10] = 10'(cur_e.left + 60*k);
        if (ship_left_o !== want_ships || top_pos_o !== 10'(cur_e.top) ||
            bot_pos_o !== 10'(cur_e.top + 19) || alive_o !== cur_e.alive ||
            alive_cnt_o !== 4'($countones(cur_e.alive)) || moving_o !== cur_e.mv ||
            cleared_o !== cur_e.cl || landed_o !== cur_e.ld) begin
          n_fail++;
          $display("FAIL %s: got left=%0d top=%0d bot=%0d alive=%h cnt=%0d mv=%b cl=%b ld=%b ships=%h | want left=%0d top=%0d bot=%0d alive=%h cnt=%0d mv=%b cl=%b ld=%b ships=%h",
                   cur_e.tag, ship_left_o[9:0], top_pos_o, bot_pos_o, alive_o, alive_cnt_o,
                   moving_o, cleared_o, landed_o, ship_left_o,
                   cur_e.left, cur_e.top, cur_e.top + 19, cur_e.alive, $countones(cur_e.alive),
                   cur_e.mv, cur_e.cl, cur_e.ld, want_ships);
        end
      end
    end
    prev_obs = obs;
    if (done && !reported) begin
      while (exp_q.size() > 0) begin
        cur_e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_event %s: got no output event, want left=%0d top=%0d alive=%h",
                 cur_e.tag, cur_e.left, cur_e.top, cur_e.alive);
      end
      reported = 1'b1;
    end
  end

  function automatic void push(input string tag, input int left, input int top,
                               input logic [7:0] alive, input logic mv, input logic cl, input logic ld);
    exp_t e;
    e.tag = tag; e.left = left; e.top = top; e.alive = alive;
    e.mv = mv; e.cl = cl; e.ld = ld;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_i = 1'b1; cyc();
      frame_i = 1'b0; cyc();
    end
  endtask

  task automatic ticks(input int n);
    frames(30 * n);
  endtask

  task automatic do_probe();
    probe = 1'b1; cyc();
    probe = 1'b0; cyc();
  endtask

  task automatic hit(input int idx);
    hit_v_i = 1'b1; hit_idx_i = 3'(idx); cyc();
    hit_v_i = 1'b0; cyc();
  endtask

  task automatic pulse_start();
    start_i = 1'b1; cyc();
    start_i = 1'b0; cyc();
  endtask

  task automatic do_reset();
    reset_i = 1'b1; cyc(2);
    reset_i = 1'b0; cyc();
  endtask

  // full row bounces between left 0 and 180; descent j lands the top at 40+20j
  task automatic bounce_down(input int last_j, input string pfx);
    for (int j = 1; j <= last_j; j++) begin
      push($sformatf("%s_desc%0d", pfx, j), (j % 2 == 1) ? 180 : 0, 40 + 20*j, 8'hFF,
           (j != 19), 1'b0, (j == 19));
      ticks((j == 1) ? 18 : 19);
    end
  endtask

  initial begin
    cyc(4);
    reset_i = 1'b0;
    cyc();
    armed = 1'b1;

    push("reset", 10, 40, 8'hFF, 0, 0, 0);
    do_probe();
    hit(2);
    push("idle_hit", 10, 40, 8'hFF, 0, 0, 0);
    do_probe();

`ifdef ENEMY_FLEET_SPEEDUP_EN
    push("su_start", 10, 40, 8'hFF, 1, 0, 0);
    pulse_start();
    frames(11); push("su_f11", 10, 40, 8'hFF, 1, 0, 0); do_probe();
    frames(1);  push("su_f12", 20, 40, 8'hFF, 1, 0, 0); do_probe();
    push("su_k7", 20, 40, 8'h7F, 1, 0, 0); hit(7);
    push("su_k6", 20, 40, 8'h3F, 1, 0, 0); hit(6);
    push("su_k5", 20, 40, 8'h1F, 1, 0, 0); hit(5);
    frames(11); push("su_old11", 20, 40, 8'h1F, 1, 0, 0); do_probe();
    frames(1);  push("su_old12", 30, 40, 8'h1F, 1, 0, 0); do_probe();
    frames(8);  push("su_new8", 30, 40, 8'h1F, 1, 0, 0); do_probe();
    frames(1);  push("su_new9", 40, 40, 8'h1F, 1, 0, 0); do_probe();
`else
    push("start", 10, 40, 8'hFF, 1, 0, 0);
    pulse_start();
    ticks(17); push("t17", 180, 40, 8'hFF, 1, 0, 0); do_probe();
    push("t18_desc", 180, 60, 8'hFF, 1, 0, 0); ticks(1);
    ticks(1); push("t19_left", 170, 60, 8'hFF, 1, 0, 0); do_probe();
    push("hit3", 170, 60, 8'hF7, 1, 0, 0); hit(3);
    hit(3); push("hit3_again", 170, 60, 8'hF7, 1, 0, 0); do_probe();

    push("reset_mid", 10, 40, 8'hFF, 0, 0, 0); do_reset();
    push("start2", 10, 40, 8'hFF, 1, 0, 0); pulse_start();
    push("k7", 10, 40, 8'h7F, 1, 0, 0); hit(7);
    push("k6", 10, 40, 8'h3F, 1, 0, 0); hit(6);
    ticks(29); push("r300", 300, 40, 8'h3F, 1, 0, 0); do_probe();
    push("r300_desc", 300, 60, 8'h3F, 1, 0, 0); ticks(1);

    push("reset2", 10, 40, 8'hFF, 0, 0, 0); do_reset();
    push("start3", 10, 40, 8'hFF, 1, 0, 0); pulse_start();
    bounce_down(19, "land");
    frames(60); push("land_hold", 180, 420, 8'hFF, 0, 0, 1); do_probe();
    push("restart", 10, 40, 8'hFF, 1, 0, 0); pulse_start();

    bounce_down(18, "clr");
    for (int i = 0; i < 7; i++) begin
      push($sformatf("clr_k%0d", i), 0, 400, 8'(8'hFF << (i + 1)), 1, 0, 0);
      hit(i);
    end
    ticks(18);
    frames(29);
    push("clear_beats_land", 180, 420, 8'h00, 0, 1, 0);
    frame_i = 1'b1; hit_v_i = 1'b1; hit_idx_i = 3'd7; cyc();
    frame_i = 1'b0; hit_v_i = 1'b0; cyc();
    hit(0); frames(40); push("cleared_hold", 180, 420, 8'h00, 0, 1, 0); do_probe();

    push("reset3", 10, 40, 8'hFF, 0, 0, 0); do_reset();
    hit(3); push("idle_hit2", 10, 40, 8'hFF, 0, 0, 0); do_probe();
`endif

    cyc(2);
    done = 1'b1;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_fleet.md
ENEMY_FLEET -- requirements
Module: enemy_fleet

Interface
REQ-001 The block SHALL provide the following parameters (name, default, meaning):
- num_ships_p, 8: ships in the row (1..16).
- ship_width_p, 40: ship width in pixels.
- ship_height_p, 20: ship height in pixels.
- spacing_p, 20: gap between adjacent ships.
- step_x_p, 10: horizontal pixels per move tick.
- step_y_p, 20: descent pixels per bounce.
- left_start_p, 10: reset left edge of ship 0.
- top_start_p, 40: reset top edge of the row.
- screen_right_p, 639: rightmost legal pixel column.
- land_line_p, 440: bottom row at which the fleet has landed.
- frames_per_move_p, 30: frames between move ticks.
- min_period_p, 4: speed-up base period.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1: the only clock.
- reset_i, in, 1: synchronous, active-high reset.
- frame_i, in, 1: one-cycle pulse per display frame.
- start_i, in, 1: start or restart the wave.
- hit_v_i, in, 1: player shot hit valid.
- hit_idx_i, in, $clog2(num_ships_p): index of the ship that was hit.
- ship_left_o, out, 10*num_ships_p: left edge of ship k in bits [10k+9:10k].
- top_pos_o, out, 10: row top edge.
- bot_pos_o, out, 10: top_pos_o + ship_height_p - 1.
- alive_o, out, num_ships_p: per-ship alive mask.
- alive_cnt_o, out, $clog2(num_ships_p+1): number of live ships.
- moving_o, out, 1: high in MOVE_RIGHT or MOVE_LEFT.
- cleared_o, out, 1: all ships destroyed.
- landed_o, out, 1: fleet reached land_line_p.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, MOVE_RIGHT, MOVE_LEFT, CLEARED and LANDED.
REQ-004 IDLE SHALL go to MOVE_RIGHT on start_i; CLEARED or LANDED plus start_i SHALL reload left_start_p and top_start_p, set alive all-ones, clear the frame counter and go to MOVE_RIGHT in one cycle.
REQ-005 A frame counter SHALL count frame_i pulses only in the move states; a move tick SHALL fire on the frame_i pulse that makes count == period-1, and the counter SHALL then wrap to 0.
REQ-006 The ship k left edge SHALL be fleet_left + k*(ship_width_p+spacing_p), computed as 10-bit unsigned.
REQ-007 Bounce edges SHALL be alive-aware: the right edge is the right edge of the highest-index live ship, and the left edge is the left edge of the lowest-index live ship.
REQ-008 On a tick in MOVE_RIGHT, if right edge + step_x_p <= screen_right_p then fleet_left SHALL increase by step_x_p; otherwise fleet_left SHALL hold, top SHALL increase by step_y_p, and the state SHALL become MOVE_LEFT.
REQ-009 On a tick in MOVE_LEFT, if left edge >= step_x_p then fleet_left SHALL decrease by step_x_p; otherwise the block SHALL descend as in REQ-008 and the state SHALL become MOVE_RIGHT.
REQ-010 If a descent makes top + ship_height_p >= land_line_p, the state SHALL become LANDED instead of the reversed move state; landed_o SHALL be high in LANDED only.
REQ-011 In a move state, hit_v_i with a live, in-range index SHALL clear that alive bit on the next clock; hits on dead, out-of-range or non-moving ships SHALL be ignored.
REQ-012 When a hit clears the last live ship, the state SHALL become CLEARED on the next clock; cleared_o SHALL be high in CLEARED only; CLEARED SHALL take priority over LANDED in the same cycle.
REQ-013 A hit and a tick in the same cycle SHALL both take effect; edge evaluation SHALL use the pre-hit alive mask.
REQ-014 Positions SHALL hold in IDLE, CLEARED and LANDED.

Reset
REQ-015 reset_i SHALL override all inputs and set: state IDLE, fleet_left = left_start_p, top_pos_o = top_start_p, alive_o all-ones, alive_cnt_o = num_ships_p, frame counter 0, and moving_o, cleared_o and landed_o all 0; reset mid-wave SHALL abort the wave with no residual state.

Configuration
REQ-016 With ENEMY_FLEET_SPEEDUP_EN defined, period SHALL be min_period_p + alive_cnt_o; without it, period SHALL be frames_per_move_p; the period SHALL be sampled at each counter wrap.

Structure
REQ-017 A shared package enemy_pkg SHALL hold the fleet state enum and the 10-bit position type.
REQ-018 Move timing SHALL reuse the existing counter sub-module; the alive-edge priority encoders SHALL be local functions.

Verification (defaults, no speed-up unless stated)
REQ-019 Start at reset, then 17 ticks -> fleet_left = 180, top 40; tick 18 -> top 60, fleet_left 180, state MOVE_LEFT.
REQ-020 Kill ships 7 then 6 in MOVE_RIGHT -> the row travels to fleet_left = 300 (ship 5 right edge 639); the next tick descends.
REQ-021 Force repeated bounces -> the descent that yields top = 420 sets landed_o = 1 and holds positions; start_i restores left 10, top 40, alive 0xFF.
REQ-022 Hit idx 3 twice, then a hit during IDLE -> alive = 0xF7, with no further change.
REQ-023 Hit the last live ship on the same cycle as a landing descent -> cleared_o = 1, landed_o = 0.
REQ-024 With ENEMY_FLEET_SPEEDUP_EN: 8 alive gives ticks every 12 frames; after 3 kills, ticks come every 9 frames from the next wrap.
